kp_scan_ctrl: RTL and testbench

// Parametrised keypad scanner: drives one active-low column at a time, samples the active-low rows,

---
 rtl/kp_pkg.sv | 21 ++
 rtl/kp_evt_fifo.sv | 58 +++++
 rtl/kp_scan_ctrl.sv | 167 ++++++++++++++++
 tb/tb_kp_scan_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kp_pkg.sv
// Shared keypad definitions: scan FSM states, key-identity sentinel and the 4x4 legend map.
package kp_pkg;

  typedef enum logic {SCAN, EVAL} kp_state_t;

  // Key identity is row*NCOLS+col; all-ones marks "no key" and is never a valid index.
  localparam int unsigned KP_IDW = 8;
  localparam logic [KP_IDW-1:0] KP_NONE = '1;

  localparam logic [3:0] KP_MAP [4][4] = '{
    '{4'd1,  4'd2, 4'd3,  4'd10},
    '{4'd4,  4'd5, 4'd6,  4'd11},
    '{4'd7,  4'd8, 4'd9,  4'd12},
    '{4'd14, 4'd0, 4'd15, 4'd13}
  };

  function automatic logic [3:0] kp_map_code(input logic [3:0] idx);
    return KP_MAP[idx[3:2]][idx[1:0]];
  endfunction

endpackage

// File: rtl/kp_evt_fifo.sv
// Small key-event queue with a sticky overflow flag; a push into a full queue is dropped
// unless a pop frees the slot in the same cycle.
module kp_evt_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             r_ovf;
  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_push_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_do_pop) r_rd <= r_rd + AW'(1);
      if (i_push && !w_do_push) r_ovf <= 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data     = r_mem[r_rd];
  assign o_overflow = r_ovf;

endmodule

// File: rtl/kp_scan_ctrl.sv
// Keypad scanner: one-hot-low column drive, synchronised row sense, ghost rejection,
// scan-level debounce and queued press events.
module kp_scan_ctrl
  import kp_pkg::*;
#(
  parameter int unsigned NROWS      = 4,
  parameter int unsigned NCOLS      = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEBOUNCE   = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAP_EN     = 1,
  localparam int unsigned KW        = $clog2(NROWS*NCOLS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NROWS-1:0] kpr,
  output logic [NCOLS-1:0] kpc,
  output logic             kphit,
  output logic [KW-1:0]    key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             multi_key,
  output logic             overflow
);

  localparam int unsigned CW  = $clog2(NCOLS);
  localparam int unsigned DW  = $clog2(SCAN_DIV);
  localparam int unsigned DBW = $clog2(DEBOUNCE+1);

  if (MAP_EN != 0 && (NROWS != 4 || NCOLS != 4)) begin : g_bad_map
    $error("kp_scan_ctrl: MAP_EN=1 requires a 4x4 keypad");
  end
  if (NROWS*NCOLS >= 255) begin : g_bad_size
    $error("kp_scan_ctrl: keypad too large for key identity width");
  end

  kp_state_t                    r_state;
  logic [CW-1:0]                r_col;
  logic [DW-1:0]                r_dwell;
  logic [NCOLS-1:0]             r_kpc;
  logic [NROWS-1:0]             r_kpr_s1;
  logic [NROWS-1:0]             r_kpr_s2;
  logic [NCOLS-1:0][NROWS-1:0]  r_snap;
  logic [KP_IDW-1:0]            r_cand;
  logic [KP_IDW-1:0]            r_stable;
  logic [DBW-1:0]               r_cnt;
  logic                         r_kphit;
  logic                         r_multi;

  logic [1:0]                   w_nkeys;
  logic [KP_IDW-1:0]            w_hit_idx;
  logic [KP_IDW-1:0]            w_snap_id;
  logic [KP_IDW-1:0]            w_cand_nx;
  logic [DBW-1:0]               w_cnt_nx;
  logic                         w_accept;
  logic                         w_push;
  logic [KW-1:0]                w_push_code;
  logic                         w_empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_kpr_s1 <= '1;
      r_kpr_s2 <= '1;
    end else begin
      r_kpr_s1 <= kpr;
      r_kpr_s2 <= r_kpr_s1;
    end
  end

  // Saturating pressed-bit count; the hit index is only meaningful when exactly one is set.
  always_comb begin
    w_nkeys   = '0;
    w_hit_idx = KP_NONE;
    for (int unsigned c = 0; c < NCOLS; c++) begin
      for (int unsigned r = 0; r < NROWS; r++) begin
        if (r_snap[c][r]) begin
          if (w_nkeys != 2'd2) w_nkeys = w_nkeys + 2'd1;
          w_hit_idx = KP_IDW'(r*NCOLS + c);
        end
      end
    end
    w_snap_id = (w_nkeys == 2'd1) ? w_hit_idx : KP_NONE;
  end

  // Acceptance uses the post-update candidate/count so DEBOUNCE identical scans commit on the last one.
  always_comb begin
    if (w_snap_id == r_cand) begin
      w_cand_nx = r_cand;
      w_cnt_nx  = (r_cnt == DBW'(DEBOUNCE)) ? r_cnt : r_cnt + DBW'(1);
    end else begin
      w_cand_nx = w_snap_id;
      w_cnt_nx  = DBW'(1);
    end
    w_accept = (w_cnt_nx == DBW'(DEBOUNCE)) && (w_cand_nx != r_stable);
    w_push   = (r_state == EVAL) && w_accept && (w_cand_nx != KP_NONE);
    if (MAP_EN != 0) w_push_code = KW'(kp_map_code(w_cand_nx[3:0]));
    else             w_push_code = w_cand_nx[KW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= SCAN;
      r_col    <= '0;
      r_dwell  <= '0;
      r_kpc    <= '1;
      r_snap   <= '0;
      r_cand   <= KP_NONE;
      r_stable <= KP_NONE;
      r_cnt    <= '0;
      r_kphit  <= 1'b0;
      r_multi  <= 1'b0;
    end else begin
      case (r_state)
        SCAN: begin
          r_kpc <= ~(NCOLS'(1) << r_col);
          if (r_dwell == DW'(SCAN_DIV-1)) begin
            r_snap[r_col] <= ~r_kpr_s2;
            r_dwell       <= '0;
            if (r_col == CW'(NCOLS-1)) begin
              r_state <= EVAL;
              r_kpc   <= '1;
            end else begin
              r_col <= r_col + CW'(1);
              r_kpc <= ~(NCOLS'(1) << (r_col + CW'(1)));
            end
          end else begin
            r_dwell <= r_dwell + DW'(1);
          end
        end
        EVAL: begin
          r_state <= SCAN;
          r_col   <= '0;
          r_dwell <= '0;
          r_kpc   <= ~NCOLS'(1);
          r_cand  <= w_cand_nx;
          r_cnt   <= w_cnt_nx;
          r_multi <= (w_nkeys == 2'd2);
          if (w_accept) begin
            r_stable <= w_cand_nx;
            r_kphit  <= (w_cand_nx != KP_NONE);
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  kp_evt_fifo #(
    .WIDTH (KW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_push_data (w_push_code),
    .i_pop       (key_valid & key_ready),
    .o_data      (key_code),
    .o_empty     (w_empty),
    .o_overflow  (overflow)
  );

  assign key_valid = ~w_empty;
  assign kpc       = r_kpc;
  assign kphit     = r_kphit;
  assign multi_key = r_multi;

endmodule

// File: tb/tb_kp_scan_ctrl.sv
// Directed bench for kp_scan_ctrl: a switch-matrix model drives the rows from the column drive.
module tb_kp_scan_ctrl;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [3:0]      kpr;
  logic [3:0]      kpc;
  logic            kphit;
  logic [3:0]      key_code;
  logic            key_valid;
  logic            key_ready = 1'b0;
  logic            multi_key;
  logic            overflow;
  logic [3:0][3:0] pressed;
  int unsigned     n_checks = 0;
  int unsigned     n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    kpr = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !kpc[c]) kpr[r] = 1'b0;
  end

  kp_scan_ctrl #(
    .NROWS      (4),
    .NCOLS      (4),
    .SCAN_DIV   (4),
    .DEBOUNCE   (3),
    .FIFO_DEPTH (4),
    .MAP_EN     (1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .kpr       (kpr),
    .kpc       (kpc),
    .kphit     (kphit),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .multi_key (multi_key),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge inside the EVAL cycle (all columns released).
  task automatic wait_eval();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (kpc === 4'hF) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_err++;
      $error("FAIL eval_timeout: observed=no EVAL expected=EVAL within 40 cycles");
    end
  endtask

  // Returns just after the EVAL edge, i.e. at the start of a fresh scan.
  task automatic scans(input int n);
    repeat (n) begin
      wait_eval();
      @(negedge clk);
    end
  endtask

  task automatic apply(input logic [3:0][3:0] m);
    scans(1);
    pressed = m;
  endtask

  task automatic key_set(input int r, input int c);
    logic [3:0][3:0] m;
    m = '0;
    m[r][c] = 1'b1;
    apply(m);
  endtask

  task automatic key_clear();
    apply('0);
  endtask

  task automatic pop_chk(input string tag, input logic [3:0] exp);
    chk({tag, "_valid"}, key_valid, 1);
    chk(tag, key_code, exp);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  int seq_r [5] = '{0, 0, 0, 1, 1};
  int seq_c [5] = '{0, 1, 2, 0, 1};

  initial begin
    logic [3:0][3:0] m;
    pressed = '0;

    // Reset state and column sequence
    repeat (3) @(negedge clk);
    chk("rst_kpc", kpc, 4'hF);
    chk("rst_kphit", kphit, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_multi", multi_key, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_code", key_code, 0);
    reset_n = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      case (n)
        1:  chk("kpc_c0", kpc, 4'b1110);
        4:  chk("kpc_c1", kpc, 4'b1101);
        8:  chk("kpc_c2", kpc, 4'b1011);
        12: chk("kpc_c3", kpc, 4'b0111);
        16: chk("kpc_eval", kpc, 4'b1111);
        17: chk("kpc_wrap", kpc, 4'b1110);
        default: ;
      endcase
    end

    // Single press row1/col1 -> code 5, one event however long held
    key_set(1, 1);
    scans(2);
    chk("t1_kphit_s2", kphit, 0);
    chk("t1_valid_s2", key_valid, 0);
    scans(1);
    chk("t1_kphit_s3", kphit, 1);
    chk("t1_valid_s3", key_valid, 1);
    chk("t1_code_s3", key_code, 4'd5);
    scans(2);
    pop_chk("t1_code", 4'd5);
    chk("t1_single", key_valid, 0);
    key_clear();
    scans(2);
    chk("t1_rel_s2", kphit, 1);
    scans(1);
    chk("t1_rel_s3", kphit, 0);
    chk("t1_rel_valid", key_valid, 0);

    // Bounce on row0/col3 then stable -> single code 10
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) key_set(0, 3);
      else            key_clear();
    end
    key_set(0, 3);
    chk("t2_bounce_valid", key_valid, 0);
    scans(2);
    chk("t2_valid_s2", key_valid, 0);
    chk("t2_kphit_s2", kphit, 0);
    scans(1);
    chk("t2_kphit_s3", kphit, 1);
    key_clear();
    scans(3);
    pop_chk("t2_code", 4'd10);
    chk("t2_single", key_valid, 0);

    // Ghost: two keys held -> multi_key, nothing accepted
    m = '0;
    m[0][0] = 1'b1;
    m[2][1] = 1'b1;
    apply(m);
    scans(1);
    chk("t3_multi", multi_key, 1);
    scans(2);
    chk("t3_multi_s3", multi_key, 1);
    chk("t3_kphit", kphit, 0);
    chk("t3_valid", key_valid, 0);
    m[2][1] = 1'b0;
    apply(m);
    scans(1);
    chk("t3_multi_clr", multi_key, 0);
    scans(1);
    chk("t3_valid_s2", key_valid, 0);
    scans(1);
    chk("t3_kphit_s3", kphit, 1);
    key_clear();
    scans(3);
    pop_chk("t3_code", 4'd1);
    chk("t3_single", key_valid, 0);

    // Backpressure: five presses into a four-deep queue
    for (int k = 0; k < 5; k++) begin
      key_set(seq_r[k], seq_c[k]);
      scans(3);
      if (k == 3) chk("t4_ovf_at4", overflow, 0);
      key_clear();
    end
    scans(3);
    chk("t4_ovf", overflow, 1);
    pop_chk("t4_q0", 4'd1);
    pop_chk("t4_q1", 4'd2);
    pop_chk("t4_q2", 4'd3);
    pop_chk("t4_q3", 4'd4);
    chk("t4_empty", key_valid, 0);
    chk("t4_ovf_sticky", overflow, 1);

    // Reset in the middle of debouncing row2/col2
    key_set(2, 2);
    scans(2);
    reset_n = 1'b0;
    pressed = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    scans(4);
    chk("t5_valid", key_valid, 0);
    chk("t5_kphit", kphit, 0);
    chk("t5_ovf", overflow, 0);

    // Push and pop on a full queue in the same cycle
    for (int k = 0; k < 4; k++) begin
      key_set(seq_r[k], seq_c[k]);
      scans(3);
      key_clear();
    end
    chk("t6_full_valid", key_valid, 1);
    chk("t6_full_ovf", overflow, 0);
    key_set(1, 1);
    scans(2);
    wait_eval();
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    chk("t6_ovf", overflow, 0);
    chk("t6_kphit", kphit, 1);
    key_clear();
    scans(3);
    pop_chk("t6_q0", 4'd2);
    pop_chk("t6_q1", 4'd3);
    pop_chk("t6_q2", 4'd4);
    pop_chk("t6_q3", 4'd5);
    chk("t6_empty", key_valid, 0);
    chk("t6_ovf_end", overflow, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
